// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter sharing one native memory bus.
// Define ARB_TIMEOUT_EN to add the slave-response watchdog and sticky timeout_err.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                m0_valid,
   input  logic                m0_instr,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_ready,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_valid,
   input  logic                m1_instr,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_ready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                s_valid,
   output logic                s_instr,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_ready,
   input  logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          grant,
   output logic                timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last;
   logic              w_last_nxt;
   logic              w_own_valid;
   logic              w_to_fire;
   logic              w_done;
   logic [DATA_W-1:0] w_rsp_data;

   if (TIMEOUT < 1 || DATA_W % 8 != 0) begin : g_cfg_check
      $error("mem_bus_arbiter: TIMEOUT must be >= 1 and DATA_W a multiple of 8");
   end

   assign w_own_valid = ((r_state == G0) && m0_valid) || ((r_state == G1) && m1_valid);
   assign w_done      = w_own_valid && (s_ready || w_to_fire);
   assign grant       = r_state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // A tie goes to the master that was not served last; every grant ends in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (m0_valid && m1_valid) begin
               w_state_nxt = r_last ? G0 : G1;
            end else if (m0_valid) begin
               w_state_nxt = G0;
            end else if (m1_valid) begin
               w_state_nxt = G1;
            end
         end
         G0, G1: begin
            if (!w_own_valid) begin
               w_state_nxt = IDLE;
            end else if (w_done) begin
               w_state_nxt = IDLE;
               w_last_nxt  = (r_state == G1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_valid  = 1'b0;
      s_instr  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m0_rdata = '0;
      m1_ready = 1'b0;
      m1_rdata = '0;
      case (r_state)
         G0: begin
            s_valid  = m0_valid;
            s_instr  = m0_instr;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = w_done;
            if (w_done) begin
               m0_rdata = w_rsp_data;
            end
         end
         G1: begin
            s_valid  = m1_valid;
            s_instr  = m1_instr;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = w_done;
            if (w_done) begin
               m1_rdata = w_rsp_data;
            end
         end
         default: ;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(32'hDEAD_BEEF);

   logic [CNT_W-1:0] r_wd_cnt;
   logic             r_to_err;

   // Fires on the TIMEOUT-th granted cycle; a coincident s_ready takes priority.
   assign w_to_fire   = w_own_valid && !s_ready && (r_wd_cnt == CNT_W'(TIMEOUT - 1));
   assign w_rsp_data  = w_to_fire ? TO_DATA : s_rdata;
   assign timeout_err = r_to_err;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wd_cnt <= '0;
         r_to_err <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_wd_cnt <= '0;
         end else if (!s_ready) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end
         if (w_to_fire) begin
            r_to_err <= 1'b1;
         end
      end
   end
`else
   assign w_to_fire   = 1'b0;
   assign w_rsp_data  = s_rdata;
   assign timeout_err = 1'b0;
`endif

endmodule
